ten_gig_tx_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares the single 10G MAC transmit AXI-Stream port (64-bit data, 32-bit tuser, 8-bit tkeep) between two requesters.
- Typical requesters: a user data path and a control/ARP responder.
- Sits between the requesters and the MAC transmit port.
- Runs in the xgmii clock domain.
- Holds off new grants while the PCS link is down, and enforces a programmable idle gap between packets.

---
 rtl/ten_gig_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 22 ++
 rtl/ten_gig_tx_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_ten_gig_tx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ten_gig_pkg.sv
// Shared definitions for the 10G transmit arbiter: AXI-Stream widths,
// arbiter state encoding and a small source-index helper.
package ten_gig_pkg;

    localparam int DATA_W = 64;
    localparam int USER_W = 32;
    localparam int KEEP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // One-hot grant vector for a source index (0 -> 01, 1 -> 10).
    function automatic logic [1:0] src_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker. A lone requester always wins;
// when both request, the pointer selects the winner.
module rr_arb2
    import ten_gig_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] grant
);

    // Pick one requester, using the pointer only to break a tie.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = src_onehot(rr_ptr);
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ten_gig_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the 10G MAC transmit
// AXI-Stream port between two sources. Grants are issued only while the
// link is up, held for a whole packet, and followed by an idle gap.
module ten_gig_tx_arbiter
    import ten_gig_pkg::*;
#(
    parameter int P_IFG_CYCLES = 2,
    parameter int P_CNT_WIDTH  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_link_up,

    input  logic [DATA_W-1:0]      s0_axis_tdata,
    input  logic [USER_W-1:0]      s0_axis_tuser,
    input  logic [KEEP_W-1:0]      s0_axis_tkeep,
    input  logic                   s0_axis_tlast,
    input  logic                   s0_axis_tvalid,
    output logic                   s0_axis_tready,

    input  logic [DATA_W-1:0]      s1_axis_tdata,
    input  logic [USER_W-1:0]      s1_axis_tuser,
    input  logic [KEEP_W-1:0]      s1_axis_tkeep,
    input  logic                   s1_axis_tlast,
    input  logic                   s1_axis_tvalid,
    output logic                   s1_axis_tready,

    output logic [DATA_W-1:0]      m_axis_tdata,
    output logic [USER_W-1:0]      m_axis_tuser,
    output logic [KEEP_W-1:0]      m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,

    output logic [1:0]             o_grant,
    output logic                   o_busy,
    output logic [P_CNT_WIDTH-1:0] o_pkt_cnt0,
    output logic [P_CNT_WIDTH-1:0] o_pkt_cnt1
);

    localparam int             LP_GAP_W    = 16;
    localparam logic [15:0]    LP_GAP_LAST = 16'(P_IFG_CYCLES - 1);
    localparam bit             LP_HAS_GAP  = (P_IFG_CYCLES > 0);

    state_t                 state_r;
    state_t                 state_s;
    logic [1:0]             grant_r;
    logic                   rr_ptr_r;
    logic [LP_GAP_W-1:0]    gap_cnt_r;
    logic [P_CNT_WIDTH-1:0] cnt0_r;
    logic [P_CNT_WIDTH-1:0] cnt1_r;

    logic [1:0]             req_s;
    logic [1:0]             pick_s;
    logic                   start_s;
    logic                   last_fire_s;
    logic                   gap_done_s;

    // Granted-source view of the stream, used for end-of-packet detection.
    logic                   sel_valid_s;
    logic                   sel_last_s;

    assign req_s       = {s1_axis_tvalid, s0_axis_tvalid};
    assign start_s     = (state_r == ST_IDLE) && i_link_up && (req_s != 2'b00);
    assign sel_valid_s = grant_r[1] ? s1_axis_tvalid : s0_axis_tvalid;
    assign sel_last_s  = grant_r[1] ? s1_axis_tlast  : s0_axis_tlast;
    assign last_fire_s = (state_r == ST_BUSY) && sel_valid_s && m_axis_tready && sel_last_s;
    assign gap_done_s  = (gap_cnt_r == LP_GAP_LAST);

    rr_arb2 u_rr_arb2 (
        .req    (req_s),
        .rr_ptr (rr_ptr_r),
        .grant  (pick_s)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode: grant in IDLE, hold for a packet, then idle gap.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_fire_s) begin
                    state_s = LP_HAS_GAP ? ST_GAP : ST_IDLE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_GAP: begin
                if (gap_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode: zero-latency mux from the owning source while BUSY.
    always_comb begin
        m_axis_tdata   = {DATA_W{1'b0}};
        m_axis_tuser   = {USER_W{1'b0}};
        m_axis_tkeep   = {KEEP_W{1'b0}};
        m_axis_tlast   = 1'b0;
        m_axis_tvalid  = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        if (state_r == ST_BUSY) begin
            case (grant_r)
                2'b01: begin
                    m_axis_tdata   = s0_axis_tdata;
                    m_axis_tuser   = s0_axis_tuser;
                    m_axis_tkeep   = s0_axis_tkeep;
                    m_axis_tlast   = s0_axis_tlast;
                    m_axis_tvalid  = s0_axis_tvalid;
                    s0_axis_tready = m_axis_tready;
                end
                2'b10: begin
                    m_axis_tdata   = s1_axis_tdata;
                    m_axis_tuser   = s1_axis_tuser;
                    m_axis_tkeep   = s1_axis_tkeep;
                    m_axis_tlast   = s1_axis_tlast;
                    m_axis_tvalid  = s1_axis_tvalid;
                    s1_axis_tready = m_axis_tready;
                end
                default: begin
                    m_axis_tvalid  = 1'b0;
                end
            endcase
        end else begin
            m_axis_tvalid = 1'b0;
        end
    end

    // Owner register: latch the pick on a new grant, release on the last beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grant_r <= 2'b00;
        end else if (start_s) begin
            grant_r <= pick_s;
        end else if (last_fire_s) begin
            grant_r <= 2'b00;
        end else begin
            grant_r <= grant_r;
        end
    end

    // Round-robin pointer: after a packet, favour the other source.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_r <= 1'b0;
        end else if (last_fire_s) begin
            rr_ptr_r <= ~grant_r[1];
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Inter-packet gap counter, active only in the GAP state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gap_cnt_r <= {LP_GAP_W{1'b0}};
        end else if ((state_r == ST_GAP) && !gap_done_s) begin
            gap_cnt_r <= gap_cnt_r + 16'd1;
        end else begin
            gap_cnt_r <= {LP_GAP_W{1'b0}};
        end
    end

    // Per-source forwarded-packet counters; free-running, wrap at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt0_r <= {P_CNT_WIDTH{1'b0}};
            cnt1_r <= {P_CNT_WIDTH{1'b0}};
        end else if (last_fire_s) begin
            if (grant_r[1]) begin
                cnt1_r <= cnt1_r + P_CNT_WIDTH'(1);
            end else begin
                cnt0_r <= cnt0_r + P_CNT_WIDTH'(1);
            end
        end else begin
            cnt0_r <= cnt0_r;
            cnt1_r <= cnt1_r;
        end
    end

    assign o_grant    = grant_r;
    assign o_busy     = (state_r == ST_BUSY);
    assign o_pkt_cnt0 = cnt0_r;
    assign o_pkt_cnt1 = cnt1_r;

endmodule

// File: tb/tb_ten_gig_tx_arbiter.sv
// Randomized self-checking bench for ten_gig_tx_arbiter. A cycle-level
// reference model tracks ownership, gap and round-robin preference with
// plain integers; per-source packet queues feed the stimulus.
module tb_ten_gig_tx_arbiter;

    localparam int IFG = 2;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [31:0] user;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    logic        drv_valid [2];
    logic [63:0] drv_data  [2];
    logic [31:0] drv_user  [2];
    logic [7:0]  drv_keep  [2];
    logic        drv_last  [2];
    logic        drv_mready;
    logic        drv_link;

    logic          s0_axis_tready, s1_axis_tready;
    logic [63:0]   m_axis_tdata;
    logic [31:0]   m_axis_tuser;
    logic [7:0]    m_axis_tkeep;
    logic          m_axis_tlast, m_axis_tvalid;
    logic [1:0]    o_grant;
    logic          o_busy;
    logic [CW-1:0] o_pkt_cnt0, o_pkt_cnt1;

    ten_gig_tx_arbiter #(.P_IFG_CYCLES(IFG), .P_CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_link_up(drv_link),
        .s0_axis_tdata(drv_data[0]), .s0_axis_tuser(drv_user[0]), .s0_axis_tkeep(drv_keep[0]),
        .s0_axis_tlast(drv_last[0]), .s0_axis_tvalid(drv_valid[0]), .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata(drv_data[1]), .s1_axis_tuser(drv_user[1]), .s1_axis_tkeep(drv_keep[1]),
        .s1_axis_tlast(drv_last[1]), .s1_axis_tvalid(drv_valid[1]), .s1_axis_tready(s1_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(drv_mready),
        .o_grant(o_grant), .o_busy(o_busy), .o_pkt_cnt0(o_pkt_cnt0), .o_pkt_cnt1(o_pkt_cnt1)
    );

    // Reference model state
    int owner;        // -1 none, else owning source
    int gap_left;
    int rr;
    int cnt [2];
    int beat_idx [2];
    int stall_cnt [2];
    bit hs [2];
    bit stall_arm, link_drop_arm;
    int bubble_pct, bp_pct;
    int vectors, miscompares;
    int grant_log[$];
    logic [1:0] prev_grant;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic beat_t front(input int n);
        return (n == 0) ? q0[0] : q1[0];
    endfunction

    function automatic int qsize(input int n);
        return (n == 0) ? q0.size() : q1.size();
    endfunction

    task automatic gen_pkt(input int n, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom};
            b.user = $urandom;
            b.keep = 8'($urandom);
            b.last = (i == len - 1);
            if (n == 0) q0.push_back(b); else q1.push_back(b);
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int n = 0; n < 2; n++) begin
            if (qsize(n) == 0) begin
                drv_valid[n] = 1'b0;
                drv_data[n] = 64'd0; drv_user[n] = 32'd0; drv_keep[n] = 8'd0; drv_last[n] = 1'b0;
            end else begin
                b = front(n);
                drv_data[n] = b.data; drv_user[n] = b.user; drv_keep[n] = b.keep; drv_last[n] = b.last;
                if (drv_valid[n] && !hs[n]) begin
                    drv_valid[n] = 1'b1;
                end else if (stall_cnt[n] > 0) begin
                    drv_valid[n] = 1'b0;
                    stall_cnt[n]--;
                end else begin
                    drv_valid[n] = ($urandom_range(0, 99) >= bubble_pct);
                end
            end
        end
        drv_mready = ($urandom_range(0, 99) >= bp_pct);
        if (link_drop_arm && owner >= 0 && beat_idx[owner] == 1) begin
            drv_link = 1'b0;
            link_drop_arm = 1'b0;
        end
    endtask

    task automatic reset_model();
        owner = -1; gap_left = 0; rr = 0;
        for (int n = 0; n < 2; n++) begin
            cnt[n] = 0; beat_idx[n] = 0; stall_cnt[n] = 0; hs[n] = 1'b0;
            drv_valid[n] = 1'b0; drv_data[n] = 64'd0; drv_user[n] = 32'd0;
            drv_keep[n] = 8'd0; drv_last[n] = 1'b0;
        end
        q0.delete(); q1.delete();
        stall_arm = 1'b0; link_drop_arm = 1'b0;
        prev_grant = 2'b00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_grant"},  64'(o_grant), 64'd0);
        check_value({tag, "_busy"},   64'(o_busy), 64'd0);
        check_value({tag, "_mvalid"}, 64'(m_axis_tvalid), 64'd0);
        check_value({tag, "_mdata"},  m_axis_tdata, 64'd0);
        check_value({tag, "_tready"}, 64'({s1_axis_tready, s0_axis_tready}), 64'd0);
        check_value({tag, "_cnt"},    64'({o_pkt_cnt1, o_pkt_cnt0}), 64'd0);
    endtask

    // One clock cycle: check at negedge, advance model at posedge, drive at +1.
    task automatic step();
        bit          busy;
        logic [1:0]  exp_grant;
        logic        exp_tr [2];
        logic        exp_mvalid;
        logic [63:0] exp_data;
        logic [40:0] exp_side;
        int          nxt_owner;
        beat_t       b;

        @(negedge clk);
        busy       = (owner >= 0);
        exp_grant  = busy ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        exp_tr[0]  = busy && owner == 0 && drv_mready;
        exp_tr[1]  = busy && owner == 1 && drv_mready;
        exp_mvalid = busy ? drv_valid[owner] : 1'b0;
        exp_data   = busy ? drv_data[owner] : 64'd0;
        exp_side   = busy ? {drv_user[owner], drv_keep[owner], drv_last[owner]} : 41'd0;

        check_value("grant",  64'(o_grant), 64'(exp_grant));
        check_value("busy",   64'(o_busy), 64'(busy));
        check_value("tready0", 64'(s0_axis_tready), 64'(exp_tr[0]));
        check_value("tready1", 64'(s1_axis_tready), 64'(exp_tr[1]));
        check_value("mvalid", 64'(m_axis_tvalid), 64'(exp_mvalid));
        check_value("mdata",  m_axis_tdata, exp_data);
        check_value("mside",  64'({m_axis_tuser, m_axis_tkeep, m_axis_tlast}), 64'(exp_side));
        check_value("cnt0",   64'(o_pkt_cnt0), 64'(cnt[0]));
        check_value("cnt1",   64'(o_pkt_cnt1), 64'(cnt[1]));

        if (prev_grant == 2'b00 && o_grant != 2'b00) grant_log.push_back((o_grant == 2'b10) ? 1 : 0);
        prev_grant = o_grant;
        hs[0] = drv_valid[0] && exp_tr[0];
        hs[1] = drv_valid[1] && exp_tr[1];

        @(posedge clk);
        nxt_owner = owner;
        if (owner >= 0) begin
            if (hs[owner]) begin
                b = front(owner);
                if (b.last) begin
                    cnt[owner] = (cnt[owner] + 1) % (1 << CW);
                    rr = 1 - owner;
                    beat_idx[owner] = 0;
                    gap_left = IFG;
                    nxt_owner = -1;
                end else begin
                    beat_idx[owner]++;
                end
            end
        end else if (gap_left > 0) begin
            gap_left--;
        end else if (drv_link && (drv_valid[0] || drv_valid[1])) begin
            nxt_owner = (drv_valid[0] && drv_valid[1]) ? rr : (drv_valid[0] ? 0 : 1);
        end
        owner = nxt_owner;
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
        if (stall_arm && hs[1] && beat_idx[1] == 2) begin
            stall_cnt[1] = 5;
            stall_arm = 1'b0;
        end
        #1;
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_empty(input int limit);
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || owner >= 0 || gap_left > 0) && k < limit) begin
            step();
            k++;
        end
        check_value("drain_pending", 64'(q0.size() + q1.size()), 64'd0);
    endtask

    // Called at posedge+1: asynchronous reset mid-cycle, checked before any edge.
    task automatic reset_dut(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        reset_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive();
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        bubble_pct = 0; bp_pct = 0;
        drv_link = 1'b0; drv_mready = 1'b1;
        rst_n = 1'b0;
        reset_model();
        @(posedge clk);
        #1 check_reset_outputs("por");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Link down with both requesting, then raise link: 0,1,0,1,0,1
        for (int p = 0; p < 3; p++) begin gen_pkt(0, 4); gen_pkt(1, 4); end
        drive();
        run(10);
        grant_log.delete();
        drv_link = 1'b1;
        run_until_empty(300);
        check_value("order_len", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check_value("order", 64'(grant_log[i]), 64'(i % 2));
        check_value("cnt0_after_rr", 64'(o_pkt_cnt0), 64'd3);
        check_value("cnt1_after_rr", 64'(o_pkt_cnt1), 64'd3);

        // Source 0 only, 4-beat packets
        for (int p = 0; p < 3; p++) gen_pkt(0, 4);
        drive();
        run_until_empty(200);
        check_value("cnt0_single", 64'(o_pkt_cnt0), 64'd6);

        // Link drop on beat 2 of 8 under random backpressure
        bp_pct = 40;
        gen_pkt(0, 8); gen_pkt(1, 8);
        link_drop_arm = 1'b1;
        drive();
        run(60);
        check_value("linkdown_grant", 64'(o_grant), 64'd0);
        check_value("linkdown_left", 64'(q0.size() + q1.size()), 64'd8);
        drv_link = 1'b1;
        run_until_empty(300);

        // Source 1 stalls 5 cycles mid-packet while source 0 waits
        bp_pct = 0;
        gen_pkt(1, 8);
        stall_arm = 1'b1;
        drive();
        run(1);
        gen_pkt(0, 3);
        drive();
        run_until_empty(200);

        // Randomized traffic with bubbles, backpressure and link flaps
        bubble_pct = 30; bp_pct = 30;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 12 && q0.size() < 24) gen_pkt(0, $urandom_range(1, 8));
            if ($urandom_range(0, 99) < 12 && q1.size() < 24) gen_pkt(1, $urandom_range(1, 8));
            if ($urandom_range(0, 99) < 3) drv_link = ~drv_link;
            step();
        end
        drv_link = 1'b1; bubble_pct = 0; bp_pct = 0;
        run_until_empty(2000);

        // Counter wrap: 17 single-beat packets on a 4-bit counter
        reset_dut("wrap_rst");
        for (int p = 0; p < 17; p++) gen_pkt(0, 1);
        drive();
        run_until_empty(400);
        check_value("cnt0_wrap", 64'(o_pkt_cnt0), 64'd1);

        // Asynchronous reset in the middle of a packet
        gen_pkt(0, 8);
        drive();
        run(4);
        check_value("mid_busy", 64'(o_busy), 64'd1);
        reset_dut("mid_rst");
        run(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
